// File: rtl/ysyx_22040088_cache_pkg.sv
// Shared types and address-field helpers for the
// ysyx_22040088 instruction cache.
package ysyx_22040088_cache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int BEAT_BYTES = 8;
  localparam int WORD_BYTES = 4;
  localparam int BEAT_BITS  = BEAT_BYTES * 8;
  localparam int WORD_BITS  = WORD_BYTES * 8;
  localparam int BEAT_OFF_W = $clog2(BEAT_BYTES);

  // Byte-offset width of one line.
  function automatic int off_w(input int beat_w);
    return beat_w + BEAT_OFF_W;
  endfunction

  // Tag width left over after index and offset.
  function automatic int tag_w(
    input int addr_w,
    input int index_w,
    input int beat_w
  );
    return addr_w - index_w - off_w(beat_w);
  endfunction

endpackage

// File: rtl/ysyx_22040088_icache_array.sv
// Valid/tag/data storage for the icache: async read,
// one write port per array, flush-all on the valid bits.
module ysyx_22040088_icache_array
  import ysyx_22040088_cache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int BEAT_W  = 1,
  parameter int TAG_W   = 54
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [INDEX_W-1:0]   rd_index,
  input  logic [BEAT_W-1:0]    rd_beat,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [BEAT_BITS-1:0] rd_data,
  input  logic                 tag_we,
  input  logic                 valid_set,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 data_we,
  input  logic [BEAT_W-1:0]    wr_beat,
  input  logic [BEAT_BITS-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_W;
  localparam int BEATS = 1 << BEAT_W;

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [BEAT_BITS-1:0] data_q [LINES][BEATS];

  // Valid bits: flush wins over a same-cycle line install.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (valid_set) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag array write port (not reset).
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  // Data array write port, one beat at a time (not reset).
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[wr_index][wr_beat] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_beat];

endmodule

// File: rtl/ysyx_22040088_icache.sv
// Direct-mapped read-only icache: 0-cycle hits, beat-by-beat
// line refill over a req/rvalid memory handshake.
module ysyx_22040088_icache
  import ysyx_22040088_cache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int BEAT_W  = 1,
  parameter int ADDR_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic                 cpu_flush,
  output logic [WORD_BITS-1:0] cpu_inst,
  output logic                 cpu_stall,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [BEAT_BITS-1:0] mem_rdata,
  input  logic                 mem_rvalid
);

  localparam int OFF_W = off_w(BEAT_W);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, BEAT_W);

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [BEAT_W-1:0]  req_beat;
  logic               word_sel;
  logic               addr_unused;

  assign req_tag     = cpu_addr[ADDR_W-1:OFF_W+INDEX_W];
  assign req_index   = cpu_addr[OFF_W+INDEX_W-1:OFF_W];
  assign req_beat    = cpu_addr[OFF_W-1:BEAT_OFF_W];
  assign word_sel    = cpu_addr[2];
  assign addr_unused = ^cpu_addr[1:0];

  state_t             state, state_n;
  logic [TAG_W-1:0]   miss_tag, miss_tag_n;
  logic [INDEX_W-1:0] miss_index, miss_index_n;
  logic [BEAT_W-1:0]  beat_cnt, beat_cnt_n;
  logic               abort, abort_n;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [BEAT_BITS-1:0] rd_data;
  logic                 hit;
  logic                 tag_we;
  logic                 valid_set;
  logic                 data_we;

  assign hit = rd_valid && (rd_tag == req_tag);

  ysyx_22040088_icache_array #(
    .INDEX_W (INDEX_W),
    .BEAT_W  (BEAT_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .flush     (cpu_flush),
    .rd_index  (req_index),
    .rd_beat   (req_beat),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .tag_we    (tag_we),
    .valid_set (valid_set),
    .wr_index  (miss_index),
    .wr_tag    (miss_tag),
    .data_we   (data_we),
    .wr_beat   (beat_cnt),
    .wr_data   (mem_rdata)
  );

  // Controller state and latched miss address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      miss_tag   <= '0;
      miss_index <= '0;
      beat_cnt   <= '0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      miss_tag   <= miss_tag_n;
      miss_index <= miss_index_n;
      beat_cnt   <= beat_cnt_n;
      abort      <= abort_n;
    end
  end

  // Next state, refill sequencing and all outputs.
  always_comb begin
    state_n      = state;
    miss_tag_n   = miss_tag;
    miss_index_n = miss_index;
    beat_cnt_n   = beat_cnt;
    abort_n      = abort;
    cpu_inst     = '0;
    cpu_stall    = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    tag_we       = 1'b0;
    valid_set    = 1'b0;
    data_we      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (hit) begin
            cpu_inst = word_sel ? rd_data[63:32]
                                : rd_data[31:0];
          end else begin
            cpu_stall    = 1'b1;
            miss_tag_n   = req_tag;
            miss_index_n = req_index;
            beat_cnt_n   = '0;
            abort_n      = 1'b0;
            state_n      = REFILL;
          end
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        mem_addr  = {miss_tag, miss_index, beat_cnt,
                     {BEAT_OFF_W{1'b0}}};
        // Dropping req on the data cycle keeps one beat per pair.
        mem_req   = ~mem_rvalid;
        if (cpu_flush) begin
          abort_n = 1'b1;
        end
        if (mem_rvalid) begin
          data_we    = 1'b1;
          beat_cnt_n = beat_cnt + 1'b1;
          if (beat_cnt == '1) begin
            tag_we    = 1'b1;
            // A flush seen anywhere in the refill leaves it invalid.
            valid_set = ~abort & ~cpu_flush;
            abort_n   = 1'b0;
            state_n   = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040088_icache.sv
// Self-checking bench for ysyx_22040088_icache: vector table,
// memory responder and an instruction scoreboard.
module tb_ysyx_22040088_icache;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [63:0] cpu_addr;
  logic        cpu_flush;
  logic [31:0] cpu_inst;
  logic        cpu_stall;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;

  int checks = 0;
  int errors = 0;

  int mem_delay   = 1;
  int beats_issued = 0;
  int req_cycles   = 0;
  logic [63:0] addr_log [$];
  logic [31:0] exp_q [$];

  ysyx_22040088_icache dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_flush  (cpu_flush),
    .cpu_inst   (cpu_inst),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] beat_of(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    if (b == 64'h8000_0000) return 64'h00000413_00000093;
    if (b == 64'h8000_0008) return 64'h00000000_00100073;
    return {~b[31:0], b[31:0] ^ 32'h1357_9bdf};
  endfunction

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [63:0] b;
    b = beat_of(a);
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: rvalid after mem_delay req cycles.
  initial begin
    int wcnt;
    logic [63:0] first_addr;
    wcnt = 0;
    first_addr = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wcnt = 0;
      end else if (mem_req) begin
        req_cycles++;
        if (wcnt == 0) first_addr = mem_addr;
        else chk("mem_addr_stable", mem_addr, first_addr);
        wcnt++;
        if (wcnt >= mem_delay) begin
          @(posedge clk);
          #1;
          mem_rdata  = beat_of(first_addr);
          mem_rvalid = 1'b1;
          addr_log.push_back(first_addr);
          beats_issued++;
          @(posedge clk);
          #1;
          mem_rvalid = 1'b0;
          wcnt = 0;
        end
      end
    end
  end

  // Scoreboard: pop on every delivered instruction.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && cpu_req && !cpu_stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected: got %0h", cpu_inst);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_inst", 64'(cpu_inst), 64'(e));
        end
      end
      if (!rst && cpu_stall) begin
        chk("inst_zero_stall", 64'(cpu_inst), 64'h0);
      end
    end
  end

  task automatic fetch(input logic [63:0] a,
                       input int fa,
                       output int stalls,
                       output int beats,
                       output int reqs);
    int b0;
    int r0;
    bit done;
    b0 = beats_issued;
    r0 = req_cycles;
    stalls = 0;
    done = 1'b0;
    cpu_addr  = a;
    cpu_req   = 1'b1;
    cpu_flush = (fa == 0);
    exp_q.push_back(inst_of(a));
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (!cpu_stall) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      cpu_flush = (fa == cyc + 1);
    end
    cpu_req   = 1'b0;
    cpu_flush = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: addr %0h", a);
      exp_q.delete();
    end
    beats = beats_issued - b0;
    reqs  = req_cycles - r0;
  endtask

  typedef struct {
    logic [63:0] addr;
    int          delay;
    int          flush_at;
    int          stall;
    int          beats;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int st;
    int bt;
    int rq;
    bit seen;
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_flush = 1'b0;

    vecs[0]  = '{64'h8000_0000, 1, -1,  5, 2};
    vecs[1]  = '{64'h8000_0004, 1, -1,  0, 0};
    vecs[2]  = '{64'h8000_000C, 1, -1,  0, 0};
    vecs[3]  = '{64'h8000_0400, 1, -1,  5, 2};
    vecs[4]  = '{64'h8000_0000, 1, -1,  5, 2};
    vecs[5]  = '{64'h8000_0008, 1, -1,  0, 0};
    vecs[6]  = '{64'h8000_1010, 4, -1, 11, 2};
    vecs[7]  = '{64'h8000_1014, 4, -1,  0, 0};
    vecs[8]  = '{64'h8000_0000, 1,  0,  0, 0};
    vecs[9]  = '{64'h8000_0000, 1, -1,  5, 2};
    vecs[10] = '{64'h8000_0400, 1,  1, 10, 4};
    vecs[11] = '{64'h8000_0404, 1, -1,  0, 0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall",    64'(cpu_stall), 64'h0);
    chk("rst_mem_req",  64'(mem_req),   64'h0);
    chk("rst_mem_addr", mem_addr,       64'h0);
    chk("rst_inst",     64'(cpu_inst),  64'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      mem_delay = vecs[i].delay;
      addr_log.delete();
      fetch(vecs[i].addr, vecs[i].flush_at, st, bt, rq);
      chk($sformatf("v%0d_stall", i), 64'(st), 64'(vecs[i].stall));
      chk($sformatf("v%0d_beats", i), 64'(bt), 64'(vecs[i].beats));
      chk($sformatf("v%0d_reqcyc", i), 64'(rq),
          64'(vecs[i].beats * vecs[i].delay));
      if (vecs[i].beats >= 2 && addr_log.size() >= 2) begin
        chk($sformatf("v%0d_addr0", i), addr_log[0],
            {vecs[i].addr[63:4], 4'h0});
        chk($sformatf("v%0d_addr1", i), addr_log[1],
            {vecs[i].addr[63:4], 4'h8});
      end
    end

    // Reset in the middle of a refill, after beat 0.
    mem_delay = 4;
    bt = beats_issued;
    cpu_addr = 64'h8000_2000;
    cpu_req  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (beats_issued == bt + 1 && !mem_rvalid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rst_mid_wait: beat 0 never returned");
    end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_req",  64'(mem_req),   64'h0);
    chk("mid_rst_stall",    64'(cpu_stall), 64'h0);
    chk("mid_rst_mem_addr", mem_addr,       64'h0);
    @(posedge clk);
    #1;
    mem_delay = 1;
    fetch(64'h8000_2000, -1, st, bt, rq);
    chk("refetch_stall", 64'(st), 64'd5);
    chk("refetch_beats", 64'(bt), 64'd2);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_icache.md
Name: ysyx_22040088_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU fetch port and the shared memory port.
- Today the top level muxes the IFU read request straight onto the data-memory port. This block replaces that path:
  - Hits return an instruction in the same cycle.
  - Misses stall the IFU and refill one line, beat by beat, over a request/valid memory handshake.
  - A flush input invalidates the whole cache for fence.i.

Parameters:
- INDEX_W, 6, index bits; number of lines = 2^INDEX_W.
- BEAT_W, 1, log2 of 64-bit beats per line; line size = 8 * 2^BEAT_W bytes.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  IFU fetch request valid.
- cpu_addr  in  ADDR_W  fetch PC; bits[1:0] ignored.
- cpu_flush  in  1  one-cycle pulse that invalidates all lines.
- cpu_inst  out  32  fetched instruction; valid when cpu_req & ~cpu_stall.
- cpu_stall  out  1  IFU must hold cpu_addr and stall (drives if_stall).
- mem_req  out  1  refill beat request.
- mem_addr  out  ADDR_W  beat address, 8-byte aligned.
- mem_rdata  in  64  returned beat data.
- mem_rvalid  in  1  beat data valid; may be delayed any number of cycles by arbitration.

Behaviour:
- Address split:
  - offset = addr[BEAT_W+2:0]
  - index = addr[INDEX_W+BEAT_W+2 : BEAT_W+3]
  - tag = remaining upper bits
  - beat select = addr[BEAT_W+2:3]; word select = addr[2] (1 picks the upper 32 bits of the beat).
- Storage:
  - valid[2^INDEX_W] flops.
  - tag array and data array as flop arrays, read asynchronously.
- State machine: IDLE, REFILL.
- IDLE:
  - hit = valid[index] & tag match.
  - cpu_req & hit: cpu_stall=0 and cpu_inst=selected word, same cycle (0-cycle latency).
  - cpu_req & ~hit: cpu_stall=1 combinationally; latch tag/index into miss registers, beat counter := 0, go to REFILL.
  - ~cpu_req: cpu_stall=0, cpu_inst=32'h0.
- REFILL:
  - cpu_stall=1 in every cycle.
  - mem_req=1 with mem_addr = {miss_tag, miss_index, beat_cnt, 3'b000}.
  - On mem_rvalid: write mem_rdata to data[miss_index][beat_cnt], beat_cnt+1, and drop mem_req for that cycle only.
  - mem_req re-asserts the next cycle for the next beat; exactly one beat per req/rvalid pair.
  - On the last beat's rvalid: write tag, set valid (unless the abort flag is set), go to IDLE.
  - The following IDLE cycle hits, so miss latency = total beat wait + 1 cycle.
- Refill order: beats start at beat 0; no critical-word-first.
- cpu_flush:
  - Clears every valid bit in the cycle it is sampled.
  - In IDLE, the same-cycle hit result is still used for that cycle's cpu_inst.
  - In REFILL, the beat sequence still completes, but an abort flag suppresses setting valid. The line therefore misses again after return to IDLE.
- cpu_addr changes during a stall are a protocol violation; the refill uses the latched miss address.
- mem_rvalid outside REFILL is ignored.
- Reset (mid-refill included):
  - state=IDLE, all valid=0, beat_cnt=0, abort=0, mem_req=0, mem_addr=0.
  - The tag/data arrays are not reset.
  - Any in-flight beat is dropped, and the memory side must also be reset.
- Outputs are undefined-free:
  - cpu_inst=0 whenever cpu_stall=1.
  - mem_addr=0 in IDLE.

Decomposition:
- Shared package ysyx_22040088_cache_pkg holds:
  - the state enum (IDLE, REFILL);
  - beat size (8 bytes) and word size (4 bytes) constants;
  - address field width functions derived from INDEX_W/BEAT_W.
- One sub-module, ysyx_22040088_icache_array: valid, tag and data storage with async read, a single write port per array, and a flush-all port.
- The controller FSM stays in the top module.

Test Plan:
- Cold miss: reset, cpu_req=1, cpu_addr=0x80000000, memory returns 0x00000413_00000093 then 0x0000_0000_0010_0073 with rvalid one cycle after each req.
  - mem_addr sequence 0x80000000, 0x80000008.
  - cpu_stall high for 5 cycles.
  - cpu_inst=0x00000093 on the next cycle.
- Same-line hit: after the line above is filled, addr 0x80000004 then 0x8000000C.
  - cpu_stall=0 both cycles.
  - cpu_inst=0x00000413, then 0x00000000.
  - mem_req stays 0.
- Conflict eviction (INDEX_W=6, 16-byte lines): fetch 0x80000000, then 0x80000400 (same index, different tag), then 0x80000000 again.
  - All three miss, with 2 beats each.
- Delayed memory: rvalid arrives 4 cycles after each req.
  - mem_req stays high and mem_addr stays stable until rvalid.
  - The stall lasts 2*5+1 cycles.
- Flush: flush in IDLE after filling 0x80000000, then refetch → miss.
  - Pulse flush during beat 0 of a refill → the line completes, the next fetch of the same address misses again.
- Reset mid-refill: assert rst during REFILL after beat 0.
  - Next cycle: mem_req=0, cpu_stall=0 with cpu_req=0.
  - Refetching the address performs a full 2-beat refill.
